// File: rtl/shared_mem_arbiter_pkg.sv
// Shared defaults and tag layout for the shared-memory arbiter.
// Tag fields are placed at fixed offsets so every decoder agrees.
package shared_mem_arbiter_pkg;

  localparam int NUM_PROCS = 4;
  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 32;
  localparam int MEM_LAT   = 1;
  localparam int CNT_W     = 16;

  localparam int TAG_V_BIT  = 0;
  localparam int TAG_WE_BIT = 1;
  localparam int TAG_ID_LSB = 2;

endpackage

// File: rtl/shared_mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr.
// Walks offsets high to low so the lowest offset wins.
module shared_mem_arbiter_rr_pick #(
  parameter int K = 4
) (
  input  logic [K-1:0]         req,
  input  logic [$clog2(K)-1:0] ptr,
  output logic [K-1:0]         gnt_onehot,
  output logic [$clog2(K)-1:0] gnt_id,
  output logic                 any
);

  localparam int IW = $clog2(K);

  logic [IW:0]   sum;
  logic [IW-1:0] sel;

  always_comb begin
    gnt_onehot = '0;
    gnt_id     = '0;
    any        = 1'b0;
    sum        = '0;
    sel        = '0;
    for (int off = K - 1; off >= 0; off--) begin
      sum = {1'b0, ptr} + (IW+1)'(off);
      if (sum >= (IW+1)'(K)) begin
        sum = sum - (IW+1)'(K);
      end
      sel = sum[IW-1:0];
      if (req[sel]) begin
        gnt_onehot      = '0;
        gnt_onehot[sel] = 1'b1;
        gnt_id          = sel;
        any             = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shared_mem_arbiter.sv
// Round-robin arbiter for a pipelined single-port memory shared by K requesters.
// Tags ride alongside each command so responses return to their owner.
module shared_mem_arbiter
  import shared_mem_arbiter_pkg::*;
#(
  parameter int K       = NUM_PROCS,
  parameter int ADDR_W  = shared_mem_arbiter_pkg::ADDR_W,
  parameter int DATA_W  = shared_mem_arbiter_pkg::DATA_W,
  parameter int MEM_LAT = shared_mem_arbiter_pkg::MEM_LAT,
  parameter int CNT_W   = shared_mem_arbiter_pkg::CNT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [K-1:0]          req_valid,
  input  logic [K-1:0]          req_we,
  input  logic [K*ADDR_W-1:0]   req_addr,
  input  logic [K*DATA_W-1:0]   req_wdata,
  output logic [K-1:0]          req_ready,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic [K-1:0]          rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic [CNT_W-1:0]      conflict_cnt
);

  localparam int IW = $clog2(K);
  localparam int TW = TAG_ID_LSB + IW;

  logic [IW-1:0] ptr;
  logic [K-1:0]  gnt;
  logic [IW-1:0] gnt_id;
  logic          any;
  logic          accept;
  logic [TW-1:0] new_tag;
  logic [TW-1:0] tag_pipe [MEM_LAT+1];
  logic [TW-1:0] tag_out;
  logic [IW-1:0] tag_id;

  shared_mem_arbiter_rr_pick #(
    .K (K)
  ) u_pick (
    .req        (req_valid),
    .ptr        (ptr),
    .gnt_onehot (gnt),
    .gnt_id     (gnt_id),
    .any        (any)
  );

  assign accept    = any & rst_n;
  assign req_ready = gnt & {K{rst_n}};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (gnt_id == IW'(K-1)) ? '0 : gnt_id + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en <= accept;
      if (accept) begin
        mem_we    <= req_we[gnt_id];
        mem_addr  <= req_addr[int'(gnt_id)*ADDR_W +: ADDR_W];
        mem_wdata <= req_wdata[int'(gnt_id)*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    new_tag                     = '0;
    new_tag[TAG_V_BIT]          = accept;
    new_tag[TAG_WE_BIT]         = req_we[gnt_id];
    new_tag[TAG_ID_LSB +: IW]   = gnt_id;
  end

  // Stage 0 lines up with mem_en; the last stage lines up with mem_rdata.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s <= MEM_LAT; s++) begin
        tag_pipe[s] <= '0;
      end
    end else begin
      tag_pipe[0] <= new_tag;
      for (int s = 1; s <= MEM_LAT; s++) begin
        tag_pipe[s] <= tag_pipe[s-1];
      end
    end
  end

  assign tag_out = tag_pipe[MEM_LAT];
  assign tag_id  = tag_out[TAG_ID_LSB +: IW];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= '0;
      rsp_rdata <= '0;
    end else if (tag_out[TAG_V_BIT]) begin
      rsp_valid <= K'(1) << tag_id;
      rsp_rdata <= tag_out[TAG_WE_BIT] ? '0 : mem_rdata;
    end else begin
      rsp_valid <= '0;
      rsp_rdata <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      conflict_cnt <= '0;
    end else if ($countones(req_valid) >= 2) begin
      if (conflict_cnt != {CNT_W{1'b1}}) begin
        conflict_cnt <= conflict_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Bench for shared_mem_arbiter: two instances (MEM_LAT 1 and 3) share stimulus
// and are compared every cycle against a transaction-level model.
module tb_shared_mem_arbiter;

  localparam int K = 4;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_we;
  logic [31:0] req_addr;
  logic [127:0] req_wdata;

  logic [3:0]  rdy1, rdy3, rsp1, rsp3;
  logic        en1, en3, we1, we3;
  logic [7:0]  addr1, addr3;
  logic [31:0] wd1, wd3, rd1, rd3, mdata1, mdata3;
  logic [15:0] cnt1;
  logic [2:0]  cnt3;

  int vectors;
  int miscompares;

  shared_mem_arbiter #(
    .K(4), .ADDR_W(8), .DATA_W(32), .MEM_LAT(1), .CNT_W(16)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(rdy1),
    .mem_en(en1), .mem_we(we1), .mem_addr(addr1), .mem_wdata(wd1),
    .mem_rdata(mdata1), .rsp_valid(rsp1), .rsp_rdata(rd1),
    .conflict_cnt(cnt1)
  );

  shared_mem_arbiter #(
    .K(4), .ADDR_W(8), .DATA_W(32), .MEM_LAT(3), .CNT_W(3)
  ) u3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(rdy3),
    .mem_en(en3), .mem_we(we3), .mem_addr(addr3), .mem_wdata(wd3),
    .mem_rdata(mdata3), .rsp_valid(rsp3), .rsp_rdata(rd3),
    .conflict_cnt(cnt3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] init_val(int i);
    if (i == 'h10) return 32'hCAFE0001;
    return 32'h1000_0000 + i * 32'h0001_0003;
  endfunction

  // Memories behind each instance: MEM_LAT-deep read pipes.
  logic [31:0] mem1 [256];
  logic [31:0] mem3 [256];
  logic [31:0] pipe1;
  logic [31:0] pipe3 [3];
  bit          loaded;

  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 256; i++) begin
        mem1[i] <= init_val(i);
        mem3[i] <= init_val(i);
      end
      loaded <= 1'b1;
    end else begin
      if (en1 === 1'b1 && we1 === 1'b1) mem1[addr1] <= wd1;
      if (en3 === 1'b1 && we3 === 1'b1) mem3[addr3] <= wd3;
    end
    pipe1    <= mem1[addr1];
    pipe3[0] <= mem3[addr3];
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end

  assign mdata1 = pipe1;
  assign mdata3 = pipe3[2];

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int pick(logic [3:0] v, int p);
    for (int off = 0; off < K; off++) begin
      if (v[(p + off) % K]) return (p + off) % K;
    end
    return -1;
  endfunction

  function automatic int lat(int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic int cmax(int d);
    return (d == 0) ? 65535 : 7;
  endfunction

  logic [31:0] refmem [256];
  int          m_ptr;
  logic        m_en, m_we;
  logic [7:0]  m_addr;
  logic [31:0] m_wd;
  int          m_cnt [2];
  bit          sv  [2][8];
  int          sid [2][8];
  logic [31:0] sd  [2][8];
  int          cyc;
  bit          started;

  // Every accept is a transaction: its response is due 1+MEM_LAT edges later.
  initial begin
    int g;
    logic [31:0] rd;
    for (int i = 0; i < 256; i++) refmem[i] = init_val(i);
    m_ptr = 0; m_en = 0; m_we = 0; m_addr = 0; m_wd = 0;
    m_cnt[0] = 0; m_cnt[1] = 0; cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
      started = 1'b1;
      for (int d = 0; d < 2; d++) sv[d][(cyc + 7) % 8] = 1'b0;
      if (!rst_n) begin
        m_ptr = 0; m_en = 0; m_we = 0; m_addr = 0; m_wd = 0;
        m_cnt[0] = 0; m_cnt[1] = 0;
        for (int d = 0; d < 2; d++)
          for (int s = 0; s < 8; s++) sv[d][s] = 1'b0;
      end else begin
        g = pick(req_valid, m_ptr);
        if ($countones(req_valid) >= 2)
          for (int d = 0; d < 2; d++)
            if (m_cnt[d] < cmax(d)) m_cnt[d]++;
        m_en = (g >= 0);
        if (g >= 0) begin
          m_we   = req_we[g];
          m_addr = req_addr[g*8 +: 8];
          m_wd   = req_wdata[g*32 +: 32];
          rd     = m_we ? 32'h0 : refmem[m_addr];
          if (m_we) refmem[m_addr] = m_wd;
          m_ptr  = (g + 1) % K;
          for (int d = 0; d < 2; d++) begin
            sv[d][(cyc + 1 + lat(d)) % 8]  = 1'b1;
            sid[d][(cyc + 1 + lat(d)) % 8] = g;
            sd[d][(cyc + 1 + lat(d)) % 8]  = rd;
          end
        end
      end
    end
  end

  // Compare process: every outputs-settled point, both instances.
  initial begin
    int g, s;
    logic [3:0]  er;
    logic [3:0]  ev;
    logic [31:0] ed;
    forever begin
      @(negedge clk);
      if (started) begin
        g  = rst_n ? pick(req_valid, m_ptr) : -1;
        er = (g >= 0) ? (4'b0001 << g) : 4'b0000;
        check("req_ready_l1", {28'h0, rdy1}, {28'h0, er});
        check("req_ready_l3", {28'h0, rdy3}, {28'h0, er});
        check("mem_en_l1", {31'h0, en1}, {31'h0, m_en});
        check("mem_en_l3", {31'h0, en3}, {31'h0, m_en});
        check("mem_we_l1", {31'h0, we1}, {31'h0, m_we});
        check("mem_addr_l1", {24'h0, addr1}, {24'h0, m_addr});
        check("mem_addr_l3", {24'h0, addr3}, {24'h0, m_addr});
        check("mem_wdata_l1", wd1, m_wd);
        s = cyc % 8;
        ev = sv[0][s] ? (4'b0001 << sid[0][s]) : 4'b0000;
        ed = sv[0][s] ? sd[0][s] : 32'h0;
        check("rsp_valid_l1", {28'h0, rsp1}, {28'h0, ev});
        check("rsp_rdata_l1", rd1, ed);
        ev = sv[1][s] ? (4'b0001 << sid[1][s]) : 4'b0000;
        ed = sv[1][s] ? sd[1][s] : 32'h0;
        check("rsp_valid_l3", {28'h0, rsp3}, {28'h0, ev});
        check("rsp_rdata_l3", rd3, ed);
        check("conflict_cnt_l1", {16'h0, cnt1}, m_cnt[0]);
        check("conflict_cnt_l3", {29'h0, cnt3}, m_cnt[1]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nedge(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic we, input logic [7:0] a,
                         input logic [31:0] d);
    req_we[i]          = we;
    req_addr[i*8 +: 8] = a;
    req_wdata[i*32 +: 32] = d;
  endtask

  task automatic rand_req(input int i);
    set_req(i, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 31)), $urandom);
  endtask

  initial begin
    logic [3:0] rdy;
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    req_we = '0;
    req_addr = '0;
    req_wdata = '0;
    for (int i = 0; i < K; i++) set_req(i, 1'b0, 8'(8'h40 + i), 32'h0);
    req_valid = 4'b1111;

    // reset held for three edges with all requests pending
    repeat (2) begin
      nedge(1);
      check("rst_ready", {28'h0, rdy1}, 32'h0);
      check("rst_mem_en", {31'h0, en1}, 32'h0);
      check("rst_rsp_valid", {28'h0, rsp1}, 32'h0);
      check("rst_conflict", {16'h0, cnt1}, 32'h0);
    end
    tick();
    rst_n = 1'b1;

    // full contention: 0,1,2,3,0,1,2,3
    for (int k = 0; k < 8; k++) begin
      nedge(1);
      check("contention_grant", {28'h0, rdy1}, 32'h1 << (k % 4));
      tick();
      set_req(k % 4, 1'b0, 8'(8'h40 + k), 32'h0);
    end
    req_valid = 4'b0000;
    nedge(1);
    check("contention_cnt", {16'h0, cnt1}, 32'd8);
    check("contention_cnt_sat", {29'h0, cnt3}, 32'd7);

    // single reader at 0x10
    tick();
    set_req(2, 1'b0, 8'h10, 32'h0);
    req_valid = 4'b0100;
    nedge(1);
    check("single_grant", {28'h0, rdy1}, 32'h4);
    tick();
    req_valid = 4'b0000;
    nedge(1);
    check("single_mem_en", {31'h0, en1}, 32'h1);
    check("single_mem_addr", {24'h0, addr1}, 32'h10);
    nedge(2);
    check("single_rsp_l1", {28'h0, rsp1}, 32'h4);
    check("single_rdata_l1", rd1, 32'hCAFE0001);
    nedge(2);
    check("single_rsp_l3", {28'h0, rsp3}, 32'h4);
    check("single_rdata_l3", rd3, 32'hCAFE0001);

    // pointer at 3, requests 0 and 1: wrap to 0, then 1
    tick();
    set_req(0, 1'b0, 8'h05, 32'h0);
    set_req(1, 1'b0, 8'h06, 32'h0);
    req_valid = 4'b0011;
    nedge(1);
    check("wrap_grant0", {28'h0, rdy1}, 32'h1);
    tick();
    set_req(0, 1'b0, 8'h07, 32'h0);
    nedge(1);
    check("wrap_grant1", {28'h0, rdy1}, 32'h2);

    // write by 1, then read by 3 of the same address
    tick();
    set_req(1, 1'b1, 8'h20, 32'h5A5A5A5A);
    req_valid = 4'b0010;
    nedge(1);
    check("wr_grant", {28'h0, rdy1}, 32'h2);
    tick();
    set_req(3, 1'b0, 8'h20, 32'h0);
    req_valid = 4'b1000;
    nedge(1);
    check("rd_grant", {28'h0, rdy1}, 32'h8);
    tick();
    req_valid = 4'b0000;
    nedge(2);
    check("wr_ack_l1", {28'h0, rsp1}, 32'h2);
    check("wr_ack_data_l1", rd1, 32'h0);
    nedge(1);
    check("rd_rsp_l1", {28'h0, rsp1}, 32'h8);
    check("rd_data_l1", rd1, 32'h5A5A5A5A);
    nedge(1);
    check("wr_ack_l3", {28'h0, rsp3}, 32'h2);
    check("wr_ack_data_l3", rd3, 32'h0);
    nedge(1);
    check("rd_rsp_l3", {28'h0, rsp3}, 32'h8);
    check("rd_data_l3", rd3, 32'h5A5A5A5A);

    // reset one cycle after an accept discards the in-flight access
    tick();
    set_req(0, 1'b0, 8'h10, 32'h0);
    req_valid = 4'b0001;
    nedge(1);
    check("mid_grant", {28'h0, rdy1}, 32'h1);
    tick();
    req_valid = 4'b0000;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      nedge(1);
      check("mid_no_rsp_l1", {28'h0, rsp1}, 32'h0);
      check("mid_no_rsp_l3", {28'h0, rsp3}, 32'h0);
    end
    tick();
    set_req(3, 1'b0, 8'h11, 32'h0);
    req_valid = 4'b1001;
    nedge(1);
    check("mid_ptr_zero", {28'h0, rdy1}, 32'h1);
    tick();
    req_valid = 4'b1000;

    // randomized traffic with occasional resets
    for (int c = 0; c < 800; c++) begin
      nedge(1);
      rdy = rdy1;
      tick();
      rst_n = ($urandom_range(0, 149) != 0);
      for (int i = 0; i < K; i++) begin
        if (req_valid[i] && rdy[i]) begin
          if ($urandom_range(0, 99) < 70) rand_req(i);
          else req_valid[i] = 1'b0;
        end else if (!req_valid[i] && $urandom_range(0, 99) < 40) begin
          rand_req(i);
          req_valid[i] = 1'b1;
        end
      end
    end
    rst_n = 1'b1;
    req_valid = 4'b0000;
    nedge(8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
